muldiv_unit: RTL

Sequential unsigned 8-bit multiply/divide unit sitting directly downstream of the register file's read ports and upstream of its write port. It takes operands from `rd1`/`rd2`, iterates one bit per clock, and returns a single-cycle write-back strobe (`we3`/`wa3`/`wd3`) that drives the register file write port directly. It frees the single-cycle ALU from multiply/divide logic.

---
 rtl/muldiv_unit_pkg.sv | 11 +
 rtl/muldiv_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encodings, FSM states and iteration count shared by the multiply/divide unit.
package muldiv_unit_pkg;
  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MUL_HI = 2'b01,
    OP_DIV_Q  = 2'b10,
    OP_DIV_R  = 2'b11
  } op_t;
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
  localparam int ITERS = 8;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: bit-serial unsigned multiply/divide feeding the register-file write port.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             div_by_zero
);
  state_t state, state_n;
  op_t op_r;
  logic [WIDTH-1:0] hi, lo, b_r, hi_n, lo_n, rem;
  logic [AW-1:0] dest_r;
  logic [3:0] cnt;
  logic [WIDTH:0] sum, diff;
  logic last, dz_start;
  // hi/lo double as rem/quo for divide; op[0] selects hi/rem as the result.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    rem = {hi[WIDTH-2:0], lo[WIDTH-1]};
    diff = {1'b0, rem} - {1'b0, b_r};
    hi_n = op_r[1] ? (diff[WIDTH] ? rem : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo_n = op_r[1] ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
    last = cnt == 4'(ITERS - 1);
    dz_start = op[1] && b == '0;
    state_n = state == IDLE ? (start ? (dz_start ? WB : RUN) : IDLE) :
              state == RUN  ? (last ? WB : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      we3 <= 1'b0;
      if (state == IDLE && start) begin
        op_r <= op_t'(op);
        b_r <= b;
        dest_r <= dest;
        hi <= '0;
        lo <= a;
        cnt <= '0;
        busy <= 1'b1;
        div_by_zero <= dz_start;
        if (dz_start) begin
          done <= 1'b1;
          we3 <= dest != '0;
          wa3 <= dest;
          wd3 <= op[0] ? a : '1;
        end
      end else if (state == RUN) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt + 4'd1;
        if (last) begin
          done <= 1'b1;
          we3 <= dest_r != '0;
          wa3 <= dest_r;
          wd3 <= op_r[0] ? hi_n : lo_n;
        end
      end else if (state == WB) begin
        busy <= 1'b0;
      end
    end
  end
endmodule
